// File: rtl/mov_engine_if.sv
// Command, status and memory-port bundle for the block-move engine.
// master = decoder/memory side, slave = engine side.
interface mov_engine_if #(
  parameter int AW = 12,
  parameter int DW = 31,
  parameter int LW = 6
);
  logic          start;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [LW-1:0] len;
  logic          safe;
  logic          abort;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [AW-1:0] dst_next;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (
    output start, src, dst, len, safe, abort, rd_data,
    input  busy, done, aborted, dst_next, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, src, dst, len, safe, abort, rd_data,
    output busy, done, aborted, dst_next, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/mov_engine.sv
// Block-move engine: copies len words src->dst one word at a time over a
// single-port read/write memory, optionally memmove-safe, with abort and done.
module mov_engine #(
  parameter int AW     = 12,
  parameter int DW     = 31,
  parameter int LW     = 6,
  parameter int RD_LAT = 1
) (
  input logic         clk,
  input logic         resetn,
  mov_engine_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam int         WCW    = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam logic [AW-1:0] A_ONE = AW'(1);

  logic [2:0]     state_q,    state_d;
  logic [AW-1:0]  src_ptr_q,  src_ptr_d;
  logic [AW-1:0]  dst_ptr_q,  dst_ptr_d;
  logic [AW-1:0]  dst_base_q, dst_base_d;
  logic [LW-1:0]  len_q,      len_d;
  logic [LW-1:0]  left_q,     left_d;
  logic [LW-1:0]  wrote_q,    wrote_d;
  logic           desc_q,     desc_d;
  logic [WCW-1:0] wait_q,     wait_d;
  logic           aborted_q,  aborted_d;
  logic [AW-1:0]  dst_next_q, dst_next_d;

  logic [AW-1:0]  gap;
  logic [AW-1:0]  len_ext;
  logic [AW-1:0]  end_dst;

  assign gap     = bus.dst - bus.src;
  assign len_ext = AW'(bus.len);
  // Descending runs report the full span regardless of how many words landed.
  assign end_dst = desc_q ? dst_base_q + AW'(len_q) : dst_base_q + AW'(wrote_d);

  always_comb begin
    state_d    = state_q;
    src_ptr_d  = src_ptr_q;
    dst_ptr_d  = dst_ptr_q;
    dst_base_d = dst_base_q;
    len_d      = len_q;
    left_d     = left_q;
    wrote_d    = wrote_q;
    desc_d     = desc_q;
    wait_d     = wait_q;
    aborted_d  = aborted_q;
    dst_next_d = dst_next_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dst_base_d = bus.dst;
          len_d      = bus.len;
          left_d     = bus.len;
          wrote_d    = '0;
          aborted_d  = 1'b0;
          if (bus.len == '0) begin
            state_d    = S_DONE;
            dst_next_d = bus.dst;
          end else begin
            state_d   = S_RD;
            desc_d    = bus.safe && (gap != '0) && (gap < len_ext);
            src_ptr_d = desc_d ? bus.src + len_ext - A_ONE : bus.src;
            dst_ptr_d = desc_d ? bus.dst + len_ext - A_ONE : bus.dst;
          end
        end
      end
      S_RD: begin
        if (bus.abort) begin
          state_d    = S_DONE;
          aborted_d  = 1'b1;
          dst_next_d = end_dst;
        end else if (RD_LAT == 1) begin
          state_d = S_WR;
        end else begin
          state_d = S_WAIT;
          wait_d  = WCW'(RD_LAT - 2);
        end
      end
      S_WAIT: begin
        if (bus.abort) begin
          state_d    = S_DONE;
          aborted_d  = 1'b1;
          dst_next_d = end_dst;
        end else if (wait_q == '0) begin
          state_d = S_WR;
        end else begin
          wait_d = wait_q - WCW'(1);
        end
      end
      S_WR: begin
        wrote_d   = wrote_q + LW'(1);
        left_d    = left_q - LW'(1);
        src_ptr_d = desc_q ? src_ptr_q - A_ONE : src_ptr_q + A_ONE;
        dst_ptr_d = desc_q ? dst_ptr_q - A_ONE : dst_ptr_q + A_ONE;
        if ((left_q == LW'(1)) || bus.abort) begin
          state_d    = S_DONE;
          aborted_d  = bus.abort && (left_q != LW'(1));
          dst_next_d = end_dst;
        end else begin
          state_d = S_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      src_ptr_q  <= '0;
      dst_ptr_q  <= '0;
      dst_base_q <= '0;
      len_q      <= '0;
      left_q     <= '0;
      wrote_q    <= '0;
      desc_q     <= 1'b0;
      wait_q     <= '0;
      aborted_q  <= 1'b0;
      dst_next_q <= '0;
    end else begin
      state_q    <= state_d;
      src_ptr_q  <= src_ptr_d;
      dst_ptr_q  <= dst_ptr_d;
      dst_base_q <= dst_base_d;
      len_q      <= len_d;
      left_q     <= left_d;
      wrote_q    <= wrote_d;
      desc_q     <= desc_d;
      wait_q     <= wait_d;
      aborted_q  <= aborted_d;
      dst_next_q <= dst_next_d;
    end
  end

  // Read data arrives exactly in the WR cycle for every latency, so it is forwarded.
  assign bus.busy     = (state_q == S_RD) || (state_q == S_WAIT) || (state_q == S_WR);
  assign bus.done     = (state_q == S_DONE);
  assign bus.aborted  = aborted_q;
  assign bus.dst_next = dst_next_q;
  assign bus.rd_en    = (state_q == S_RD);
  assign bus.rd_addr  = src_ptr_q;
  assign bus.wr_en    = (state_q == S_WR);
  assign bus.wr_addr  = dst_ptr_q;
  assign bus.wr_data  = (state_q == S_WR) ? bus.rd_data : '0;

endmodule

// File: tb/tb_mov_engine.sv
// Bench for mov_engine: RD_LAT=1 and RD_LAT=3 instances run the same moves
// side by side against behavioural memories and a write scoreboard.
module tb_mov_engine;
  localparam int AW = 12;
  localparam int DW = 31;
  localparam int LW = 6;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mov_engine_if #(.AW(AW), .DW(DW), .LW(LW)) b1 ();
  mov_engine_if #(.AW(AW), .DW(DW), .LW(LW)) b3 ();

  mov_engine #(.AW(AW), .DW(DW), .LW(LW), .RD_LAT(1)) u1 (.clk(clk), .resetn(resetn), .bus(b1));
  mov_engine #(.AW(AW), .DW(DW), .LW(LW), .RD_LAT(3)) u3 (.clk(clk), .resetn(resetn), .bus(b3));

  // Memories with 1- and 3-cycle read latency plus a backdoor load port.
  logic [DW-1:0] mem1 [0:4095];
  logic [DW-1:0] mem3 [0:4095];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic [DW-1:0] r1 = '0, p0 = '0, p1 = '0, p2 = '0;
  always @(posedge clk) begin
    if (ld_en) begin
      mem1[ld_addr] <= ld_data;
      mem3[ld_addr] <= ld_data;
    end
    if (b1.wr_en) mem1[b1.wr_addr] <= b1.wr_data;
    if (b3.wr_en) mem3[b3.wr_addr] <= b3.wr_data;
    r1 <= b1.rd_en ? mem1[b1.rd_addr] : '0;
    p0 <= b3.rd_en ? mem3[b3.rd_addr] : '0;
    p1 <= p0;
    p2 <= p1;
  end
  assign b1.rd_data = r1;
  assign b3.rd_data = p2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errs = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t q1[$], q3[$];
  logic [AW-1:0] rl1[$], rl3[$], wl1[$];
  int nrd1 = 0, nwr1 = 0, nrd3 = 0, nwr3 = 0, ndone = 0;
  wr_t e1, e3;

  // Scoreboard: every observed write must match the next expected one.
  always @(negedge clk) begin
    if (resetn) begin
      if (b1.done || b3.done) ndone++;
      if (b1.rd_en) begin nrd1++; rl1.push_back(b1.rd_addr); end
      if (b3.rd_en) begin nrd3++; rl3.push_back(b3.rd_addr); end
      if (b1.wr_en) begin
        nwr1++;
        wl1.push_back(b1.wr_addr);
        if (q1.size() == 0) check("wr1_unexpected", 64'd1, 64'd0);
        else begin
          e1 = q1.pop_front();
          check("wr1_addr", 64'(b1.wr_addr), 64'(e1.a));
          check("wr1_data", 64'(b1.wr_data), 64'(e1.d));
        end
      end
      if (b3.wr_en) begin
        nwr3++;
        if (q3.size() == 0) check("wr3_unexpected", 64'd1, 64'd0);
        else begin
          e3 = q3.pop_front();
          check("wr3_addr", 64'(b3.wr_addr), 64'(e3.a));
          check("wr3_data", 64'(b3.wr_data), 64'(e3.d));
        end
      end
    end
  end

  logic [DW-1:0] sh1 [0:4095];
  logic [DW-1:0] sh3 [0:4095];

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] v);
    sh1[a] = v;
    sh3[a] = v;
    ld_en = 1'b1; ld_addr = a; ld_data = v;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Reference model: word-by-word copy on a shadow memory, pushing expected writes.
  task automatic expect_move(input bit w3, input logic [AW-1:0] s, input logic [AW-1:0] d,
                             input int len, input bit safe, input int nw);
    logic [AW-1:0] diff, sa, da;
    logic [DW-1:0] v;
    bit desc;
    diff = d - s;
    desc = safe && (diff != 0) && (int'(diff) < len);
    for (int k = 0; k < nw; k++) begin
      sa = desc ? s + AW'(len - 1 - k) : s + AW'(k);
      da = desc ? d + AW'(len - 1 - k) : d + AW'(k);
      if (w3) begin v = sh3[sa]; sh3[da] = v; q3.push_back(wr_t'{a: da, d: v}); end
      else    begin v = sh1[sa]; sh1[da] = v; q1.push_back(wr_t'{a: da, d: v}); end
    end
  endtask

  int t0 = 0;
  task automatic run(input logic [AW-1:0] s, input logic [AW-1:0] d, input int len,
                     input bit safe, input int n1, input int n3);
    expect_move(1'b0, s, d, len, safe, n1);
    expect_move(1'b1, s, d, len, safe, n3);
    b1.src = s; b1.dst = d; b1.len = LW'(len); b1.safe = safe;
    b3.src = s; b3.dst = d; b3.len = LW'(len); b3.safe = safe;
    b1.start = 1'b1; b3.start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    b1.start = 1'b0; b3.start = 1'b0;
  endtask

  int c1, c3;
  logic ab1, ab3;
  logic [AW-1:0] dn1, dn3;
  task automatic wait_done();
    bit g1, g3;
    g1 = 0; g3 = 0;
    for (int i = 0; i < 300 && !(g1 && g3); i++) begin
      @(negedge clk);
      if (!g1 && b1.done) begin g1 = 1; c1 = cyc - t0 + 1; ab1 = b1.aborted; dn1 = b1.dst_next; end
      if (!g3 && b3.done) begin g3 = 1; c3 = cyc - t0 + 1; ab3 = b3.aborted; dn3 = b3.dst_next; end
    end
    check("done1_seen", 64'(g1), 64'd1);
    check("done3_seen", 64'(g3), 64'd1);
    @(posedge clk); #1;
    check("q1_drained", 64'(q1.size()), 64'd0);
    check("q3_drained", 64'(q3.size()), 64'd0);
  endtask

  int base_r1, base_r3, base_w1, base_w3, base_wl, base_d;

  initial begin
    b1.start = 0; b1.src = '0; b1.dst = '0; b1.len = '0; b1.safe = 0; b1.abort = 0;
    b3.start = 0; b3.src = '0; b3.dst = '0; b3.len = '0; b3.safe = 0; b3.abort = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",     64'(b1.busy),     64'd0);
    check("rst_done",     64'(b1.done),     64'd0);
    check("rst_aborted",  64'(b1.aborted),  64'd0);
    check("rst_dst_next", 64'(b1.dst_next), 64'd0);
    check("rst_rd_en",    64'(b1.rd_en),    64'd0);
    check("rst_wr_en",    64'(b1.wr_en),    64'd0);
    check("rst_rd_addr",  64'(b3.rd_addr),  64'd0);
    check("rst_wr_data",  64'(b3.wr_data),  64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Plain ascending copy
    for (int i = 0; i < 10; i++) load(AW'(100 + i), DW'(i + 1));
    run(12'd100, 12'd200, 10, 1'b0, 10, 10);
    wait_done();
    check("t1_cycle1", 64'(c1), 64'd21);
    check("t1_cycle3", 64'(c3), 64'd41);
    check("t1_abort1", 64'(ab1), 64'd0);
    check("t1_dnext1", 64'(dn1), 64'd210);
    check("t1_dnext3", 64'(dn3), 64'd210);
    for (int i = 0; i < 10; i++) begin
      check("t1_mem1", 64'(mem1[200 + i]), 64'(i + 1));
      check("t1_mem3", 64'(mem3[200 + i]), 64'(i + 1));
    end

    // Zero-length move
    base_r1 = nrd1; base_w1 = nwr1; base_r3 = nrd3; base_w3 = nwr3;
    run(12'd7, 12'd55, 0, 1'b0, 0, 0);
    wait_done();
    check("t2_cycle1", 64'(c1), 64'd1);
    check("t2_cycle3", 64'(c3), 64'd1);
    check("t2_dnext1", 64'(dn1), 64'd55);
    check("t2_dnext3", 64'(dn3), 64'd55);
    check("t2_noacc1", 64'(nrd1 - base_r1 + nwr1 - base_w1), 64'd0);
    check("t2_noacc3", 64'(nrd3 - base_r3 + nwr3 - base_w3), 64'd0);

    // Forward overlap propagates the first word
    for (int i = 0; i < 4; i++) load(AW'(10 + i), DW'(32'h0100_000A + i));
    run(12'd10, 12'd11, 4, 1'b0, 4, 4);
    wait_done();
    for (int i = 0; i < 4; i++) begin
      check("t3_mem1", 64'(mem1[11 + i]), 64'h0100_000A);
      check("t3_mem3", 64'(mem3[11 + i]), 64'h0100_000A);
    end

    // Safe mode copies backwards
    for (int i = 0; i < 4; i++) load(AW'(10 + i), DW'(32'h0100_000A + i));
    base_wl = wl1.size();
    run(12'd10, 12'd11, 4, 1'b1, 4, 4);
    wait_done();
    for (int i = 0; i < 4; i++) begin
      check("t4_wr_addr", 64'(wl1[base_wl + i]), 64'(14 - i));
      check("t4_mem1", 64'(mem1[11 + i]), 64'(32'h0100_000A + i));
      check("t4_mem3", 64'(mem3[11 + i]), 64'(32'h0100_000A + i));
    end
    check("t4_dnext1", 64'(dn1), 64'd15);

    // Address wrap, RD_LAT=3 timing
    load(12'd4094, 31'h51); load(12'd4095, 31'h52); load(12'd0, 31'h53); load(12'd1, 31'h54);
    base_r1 = rl1.size(); base_r3 = rl3.size();
    run(12'd4094, 12'd0, 4, 1'b0, 4, 4);
    wait_done();
    check("t5_rd1_0", 64'(rl1[base_r1 + 0]), 64'd4094);
    check("t5_rd1_1", 64'(rl1[base_r1 + 1]), 64'd4095);
    check("t5_rd1_2", 64'(rl1[base_r1 + 2]), 64'd0);
    check("t5_rd1_3", 64'(rl1[base_r1 + 3]), 64'd1);
    check("t5_rd3_2", 64'(rl3[base_r3 + 2]), 64'd0);
    check("t5_rd3_3", 64'(rl3[base_r3 + 3]), 64'd1);
    check("t5_cycle1", 64'(c1), 64'd9);
    check("t5_cycle3", 64'(c3), 64'd17);
    check("t5_dnext3", 64'(dn3), 64'd4);

    // Abort during third read (fast instance only) plus a start while busy
    for (int i = 0; i < 10; i++) load(AW'(300 + i), DW'(32'h2000 + i));
    run(12'd300, 12'd400, 10, 1'b0, 2, 10);
    repeat (2) @(posedge clk);
    #1;
    check("t6_busy", 64'(b1.busy), 64'd1);
    b1.dst = 12'd900; b3.dst = 12'd900; b1.len = 6'd3; b3.len = 6'd3;
    b1.start = 1'b1; b3.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0; b3.start = 1'b0;
    @(posedge clk); #1;
    b1.abort = 1'b1;
    @(posedge clk); #1;
    b1.abort = 1'b0;
    wait_done();
    check("t6_cycle1", 64'(c1), 64'd6);
    check("t6_abort1", 64'(ab1), 64'd1);
    check("t6_dnext1", 64'(dn1), 64'd402);
    check("t6_abort3", 64'(ab3), 64'd0);
    check("t6_dnext3", 64'(dn3), 64'd410);
    check("t6_mem1_nowr", 64'(mem1[402] === 31'h2002), 64'd0);

    // Reset mid-transfer abandons the move with no done
    run(12'd100, 12'd500, 10, 1'b0, 10, 10);
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("t7_busy1",  64'(b1.busy),  64'd0);
    check("t7_rd_en1", 64'(b1.rd_en), 64'd0);
    check("t7_wr_en3", 64'(b3.wr_en), 64'd0);
    check("t7_done3",  64'(b3.done),  64'd0);
    check("t7_dnext1", 64'(b1.dst_next), 64'd0);
    q1.delete(); q3.delete();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    base_d = ndone;
    repeat (50) @(posedge clk);
    #1;
    check("t7_no_done", 64'(ndone - base_d), 64'd0);
    check("t7_idle3",   64'(b3.busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
